io_port_ctrl: RTL and testbench

- Memory-mapped I/O responder between the single-cycle CPU data bus (initiator) and the board I/O.
- CPU stores set three 32-bit output-port registers; these feed the 7-segment drivers.
- CPU loads return debounced switch-group values and a sticky change-status word.
- Sits beside data memory. It claims addresses in the I/O window; the CPU-side mux selects its rdata for those addresses.

---
 rtl/io_map_pkg.sv | 60 ++++++
 rtl/sw_debounce.sv | 59 +++++
 rtl/io_port_ctrl.sv | 130 +++++++++++++
 tb/tb_io_port_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// Shared address map, window decode and status layout for the board I/O
// responder. Offsets are word offsets, i.e. addr[7:2].
package io_map_pkg;

  // I/O window: addr[31:8] == 0 and addr[7] == 1, i.e. 0x80..0xFF.
  localparam logic [31:0] WIN_BASE = 32'h0000_0080;
  localparam logic [31:0] WIN_MASK = 32'hFFFF_FF80;

  // Word offsets (byte address >> 2). The three output ports are
  // deliberately consecutive so they can be decoded by index.
  localparam logic [5:0] OFS_OUT0 = 6'h20; // 0x80
  localparam logic [5:0] OFS_OUT1 = 6'h21; // 0x84
  localparam logic [5:0] OFS_OUT2 = 6'h22; // 0x88
  localparam logic [5:0] OFS_IN0  = 6'h30; // 0xC0
  localparam logic [5:0] OFS_IN1  = 6'h31; // 0xC4
  localparam logic [5:0] OFS_STAT = 6'h32; // 0xC8

  // Switch grouping: group 0 is sw[4:0] (in_port1), group 1 is sw[9:5] (in_port0).
  localparam int SW_W    = 10;
  localparam int GRP_W   = 5;
  localparam int NUM_GRP = 2;
  localparam int GRP_LO  = 0;
  localparam int GRP_HI  = 1;
  localparam int NUM_OUT = 3;

  // Bit positions of the sticky change flags inside the status word.
  localparam int STAT_CHG0 = 0; // low group (sw[4:0])
  localparam int STAT_CHG1 = 1; // high group (sw[9:5])

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_OUT0,
    SEL_OUT1,
    SEL_OUT2,
    SEL_IN0,
    SEL_IN1,
    SEL_STAT
  } reg_sel_e;

  // True when the byte address falls inside the I/O window.
  function automatic logic in_window(input logic [31:0] addr);
    return (addr & WIN_MASK) == WIN_BASE;
  endfunction

  // Map a word offset to the register it selects; unmapped offsets give SEL_NONE.
  function automatic reg_sel_e decode_ofs(input logic [5:0] ofs);
    reg_sel_e sel;
    case (ofs)
      OFS_OUT0: sel = SEL_OUT0;
      OFS_OUT1: sel = SEL_OUT1;
      OFS_OUT2: sel = SEL_OUT2;
      OFS_IN0:  sel = SEL_IN0;
      OFS_IN1:  sel = SEL_IN1;
      OFS_STAT: sel = SEL_STAT;
      default:  sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Debouncer for one already-synchronized switch group. A new value must be
// seen for DB_CYCLES consecutive clocks before it replaces the stable value;
// any return to the stable value restarts the count. 'changed' is high in
// the cycle whose closing edge commits the new value.
module sw_debounce
  #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 16,
    parameter int W         = 5
  )
  (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] stable,
    output logic         changed
  );

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [W-1:0]     st_reg;
  logic [W-1:0]     st_next;
  logic             differs;
  logic             expire;

  assign differs = (din != st_reg);
  assign expire  = (cnt_reg == CNT_LAST);

  // Count how long the input has disagreed with the stable value; commit on expiry.
  always_comb begin
    cnt_next = cnt_reg;
    st_next  = st_reg;
    if (!differs) begin
      cnt_next = '0;
    end else if (expire) begin
      st_next  = din;
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // Counter and stable value registers; reset discards any pending value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
      st_reg  <= '0;
    end else begin
      cnt_reg <= cnt_next;
      st_reg  <= st_next;
    end
  end

  assign stable  = st_reg;
  assign changed = differs & expire;

endmodule

// File: rtl/io_port_ctrl.sv
// Memory-mapped I/O responder on the single-cycle CPU data bus: three
// writable output ports driving the 7-segment logic, two debounced switch
// groups and a sticky clear-on-read change-status word. Read data is a
// combinational function of registered state so the CPU can load it in the
// same cycle it presents the address.
module io_port_ctrl
  import io_map_pkg::*;
  #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 16
  )
  (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic        io_hit,
    output logic [31:0] rdata,
    input  logic [9:0]  sw,
    output logic [31:0] out_port0,
    output logic [31:0] out_port1,
    output logic [31:0] out_port2
  );

  logic [SW_W-1:0]                s1_reg;
  logic [SW_W-1:0]                s2_reg;
  logic [NUM_OUT-1:0][31:0]       out_q;
  logic [NUM_GRP-1:0]             chg;
  logic [NUM_GRP-1:0]             grp_accept;
  logic [NUM_GRP-1:0][GRP_W-1:0]  grp_stable;
  logic [5:0]                     ofs;
  reg_sel_e                       sel;
  logic                           wr_en;
  logic                           stat_clr;
  logic [31:0]                    stat_word;

  // Address decode: addr[1:0] never take part, so misaligned accesses alias
  // onto the containing word.
  assign io_hit   = in_window(addr);
  assign ofs      = addr[7:2];
  assign sel      = decode_ofs(ofs);
  assign wr_en    = we & io_hit;
  assign stat_clr = re & io_hit & (sel == SEL_STAT);

  // Two-flop synchronizer for the raw switches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= sw;
      s2_reg <= s1_reg;
    end
  end

  // One debouncer and one sticky change flag per switch group.
  generate
    for (genvar gi = 0; gi < NUM_GRP; gi++) begin : g_grp
      logic chg_q;

      sw_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W),
        .W         (GRP_W)
      ) u_db (
        .clk     (clk),
        .reset   (reset),
        .din     (s2_reg[gi*GRP_W +: GRP_W]),
        .stable  (grp_stable[gi]),
        .changed (grp_accept[gi])
      );

      // Sticky change flag: a new acceptance beats a simultaneous status read.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          chg_q <= 1'b0;
        end else if (grp_accept[gi]) begin
          chg_q <= 1'b1;
        end else if (stat_clr) begin
          chg_q <= 1'b0;
        end
      end

      assign chg[gi] = chg_q;
    end
  endgenerate

  // Output port registers, decoded by index from the consecutive OUT offsets.
  generate
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_out
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          out_q[gi] <= '0;
        end else if (wr_en && (ofs == OFS_OUT0 + 6'(gi))) begin
          out_q[gi] <= wdata;
        end
      end
    end
  endgenerate

  assign out_port0 = out_q[0];
  assign out_port1 = out_q[1];
  assign out_port2 = out_q[2];

  // Assemble the status word from the per-group flags.
  always_comb begin
    stat_word            = '0;
    stat_word[STAT_CHG0] = chg[GRP_LO];
    stat_word[STAT_CHG1] = chg[GRP_HI];
  end

  // Same-cycle read mux; anything outside the window or unmapped reads zero.
  always_comb begin
    rdata = '0;
    if (io_hit) begin
      case (sel)
        SEL_OUT0: rdata = out_q[0];
        SEL_OUT1: rdata = out_q[1];
        SEL_OUT2: rdata = out_q[2];
        SEL_IN0:  rdata = 32'(grp_stable[GRP_HI]);
        SEL_IN1:  rdata = 32'(grp_stable[GRP_LO]);
        SEL_STAT: rdata = stat_word;
        default:  rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Self-checking bench for io_port_ctrl. Expected read values are queued when
// an access is driven and popped when the combinational read data is sampled.
module tb_io_port_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic        io_hit;
  logic [31:0] rdata;
  logic [9:0]  sw;
  logic [31:0] out_port0;
  logic [31:0] out_port1;
  logic [31:0] out_port2;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  io_port_ctrl #(
    .DB_CYCLES (16),
    .CNT_W     (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .re        (re),
    .io_hit    (io_hit),
    .rdata     (rdata),
    .sw        (sw),
    .out_port0 (out_port0),
    .out_port1 (out_port1),
    .out_port2 (out_port2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %-18s got=%08h exp=%08h ok", tag, got, exp);
    end else begin
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue an expected read value, then sample rdata mid-cycle and compare.
  task automatic sample_rd(input string tag, input logic [31:0] e);
    exp_t x;
    sb.push_back('{tag, e});
    @(negedge clk);
    if (sb.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      check_val(x.tag, rdata, x.exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag, input bit clr);
    addr = a;
    re   = clr;
    sample_rd(tag, e);
    tick();
    re   = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
    addr  = 32'h0;
  endtask

  // Called right after reset release: value must still be 0 after edge 17
  // and show up after edge 18.
  task automatic accept_window(input logic [31:0] a, input logic [31:0] e, input string tag);
    addr = a;
    for (int i = 1; i <= 18; i++) begin
      tick();
      if (i == 17) sample_rd({tag, "_e17"}, 32'h0);
      if (i == 18) sample_rd({tag, "_e18"}, e);
    end
  endtask

  initial begin
    reset = 1'b1;
    addr  = 32'h0;
    wdata = 32'h0;
    we    = 1'b0;
    re    = 1'b0;
    sw    = 10'h3FF;
    #1 reset = 1'b0;

    // Reset held with all switches on.
    repeat (3) tick();
    @(negedge clk);
    check_val("rst_out0", out_port0, 32'h0);
    check_val("rst_out1", out_port1, 32'h0);
    check_val("rst_out2", out_port2, 32'h0);
    addr = 32'hC8;
    sample_rd("rst_stat", 32'h0);
    tick();
    reset = 1'b1;
    accept_window(32'hC0, 32'h1F, "in0_after_rst");
    rd(32'hC4, 32'h1F, "in1_after_rst", 1'b0);

    // Return switches low, let them settle, clear status.
    sw = 10'h000;
    repeat (25) tick();
    rd(32'hC8, 32'h3, "stat_both", 1'b1);
    rd(32'hC8, 32'h0, "stat_cleared", 1'b0);

    // Output port writes.
    wr(32'h84, 32'h1234_5678);
    @(negedge clk);
    check_val("out1_wr", out_port1, 32'h1234_5678);
    check_val("out0_unch", out_port0, 32'h0);
    check_val("out2_unch", out_port2, 32'h0);
    tick();
    rd(32'h84, 32'h1234_5678, "rd_out1", 1'b0);
    wr(32'h80, 32'hCAFE_F00D);
    rd(32'h80, 32'hCAFE_F00D, "rd_out0", 1'b0);
    wr(32'hC0, 32'hFFFF_FFFF);
    rd(32'hC0, 32'h0, "in0_ro", 1'b0);
    wr(32'hCC, 32'h5555_5555);
    rd(32'hCC, 32'h0, "unmapped", 1'b0);

    // Outside the window: no hit, no read data, no write.
    addr  = 32'h100;
    wdata = 32'hDEAD_BEEF;
    we    = 1'b1;
    @(negedge clk);
    check_val("oow_hit", {31'b0, io_hit}, 32'h0);
    sample_rd("oow_rdata", 32'h0);
    tick();
    we = 1'b0;
    @(negedge clk);
    check_val("oow_out0", out_port0, 32'hCAFE_F00D);
    check_val("oow_out1", out_port1, 32'h1234_5678);
    check_val("oow_out2", out_port2, 32'h0);
    tick();

    // Misaligned address aliases onto 0x88.
    wr(32'h8B, 32'h0BAD_F00D);
    @(negedge clk);
    check_val("mis_out2", out_port2, 32'h0BAD_F00D);
    tick();
    rd(32'h8B, 32'h0BAD_F00D, "mis_rd", 1'b0);

    // Short glitch on sw[2] is rejected.
    sw = 10'h004;
    repeat (10) tick();
    sw = 10'h000;
    repeat (20) tick();
    rd(32'hC4, 32'h0, "glitch_in1", 1'b0);
    rd(32'hC8, 32'h0, "glitch_stat", 1'b0);

    // Held long enough: accepted and flagged.
    sw = 10'h004;
    repeat (20) tick();
    rd(32'hC4, 32'h4, "held_in1", 1'b0);
    rd(32'hC8, 32'h1, "held_stat", 1'b1);
    rd(32'hC8, 32'h0, "stat_clr_next", 1'b0);

    // High group accepted on the very edge that a status read clears.
    sw = 10'h3E4;
    repeat (17) tick();
    addr = 32'hC8;
    re   = 1'b1;
    sample_rd("stat_pre_set", 32'h0);
    tick();
    re = 1'b0;
    sample_rd("stat_set_wins", 32'h2);
    tick();
    rd(32'hC0, 32'h1F, "hi_in0", 1'b0);
    rd(32'hC8, 32'h2, "stat_hi_clr", 1'b1);
    rd(32'hC8, 32'h0, "stat_hi_gone", 1'b0);

    // Reset in the middle of a debounce (count 8) discards the pending value.
    sw = 10'h2A4;
    repeat (10) tick();
    reset = 1'b0;
    addr  = 32'hC0;
    sample_rd("midrst_in0", 32'h0);
    check_val("midrst_out1", out_port1, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    accept_window(32'hC0, 32'h15, "in0_reaccept");
    rd(32'hC4, 32'h4, "in1_reaccept", 1'b0);
    rd(32'hC8, 32'h3, "stat_reaccept", 1'b0);

    if (sb.size() != 0) check_val("sb_leftover", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
